// File: rtl/spi_peripheral.sv
// SPI responder: synchronizes the external SPI pins into the clk domain,
// shifts a buffered tx word out on poci and assembles received frames of
// 1-8 bytes (MSB first) into a zero-extended parallel word.
module spi_peripheral #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  sync_rst_n,
    input  logic [1:0]            spi_mode,
    input  logic [2:0]            byte_sel,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  tx_underrun,
    output logic                  busy,
    input  logic                  s_clk,
    input  logic                  s_cs_n,
    input  logic                  copi,
    output logic                  poci,
    output logic                  poci_oe
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [6:0] DW_L = 7'(DATA_WIDTH);

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sclk_sync_q, cs_sync_q, copi_sync_q, vld_q;
    logic                    sclk_prev_q;
    logic                    armed_q, armed_d;
    logic                    cpol_q, cpol_d, cpha_q, cpha_d;
    logic [6:0]              nbits_q, nbits_d, cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0]   buf_q, buf_d, rx_data_q, rx_data_d;
    logic                    buf_full_q, buf_full_d;
    logic                    poci_q, poci_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic                    tx_underrun_q, tx_underrun_d;

    logic                    sclk_s, cs_s, copi_s;
    logic                    edge_w, lead_w, trail_w, sample_w, shift_w;
    logic [6:0]              nbits_new;
    logic [DATA_WIDTH-1:0]   tx_word;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign copi_s = copi_sync_q[SYNC_STAGES-1];

    // Synchronizer chains, reset to the idle pin levels; vld_q marks when
    // the chain output reflects real pin samples rather than reset values.
    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            copi_sync_q <= '0;
            vld_q       <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], s_clk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], s_cs_n};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
            vld_q       <= {vld_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q <= sclk_s;
        end
    end

    // Next-state logic for the frame FSM, shifters and transmit buffer.
    always_comb begin
        state_d       = state_q;
        cpol_d        = cpol_q;
        cpha_d        = cpha_q;
        nbits_d       = nbits_q;
        cnt_d         = cnt_q;
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        buf_d         = buf_q;
        buf_full_d    = buf_full_q;
        rx_data_d     = rx_data_q;
        poci_d        = poci_q;
        rx_valid_d    = 1'b0;
        frame_err_d   = 1'b0;
        tx_underrun_d = 1'b0;
        tx_word       = '0;

        // A frame may only start after chip select has been seen high, so a
        // frame already in progress across a reset is ignored.
        armed_d = armed_q | (vld_q[SYNC_STAGES-1] & cs_s);

        edge_w   = sclk_s ^ sclk_prev_q;
        lead_w   = edge_w & (sclk_s != cpol_q);
        trail_w  = edge_w & (sclk_s == cpol_q);
        sample_w = cpha_q ? trail_w : lead_w;
        shift_w  = cpha_q ? lead_w : trail_w;

        nbits_new = {({1'b0, byte_sel} + 4'd1), 3'b000};
        if (nbits_new > DW_L) begin
            nbits_new = DW_L;
        end

        unique case (state_q)
            IDLE: begin
                if (armed_q && !cs_s) begin
                    state_d    = ACTIVE;
                    armed_d    = 1'b0;
                    cpol_d     = spi_mode[0];
                    cpha_d     = spi_mode[1];
                    nbits_d    = nbits_new;
                    cnt_d      = '0;
                    rx_shift_d = '0;
                    if (buf_full_q) begin
                        tx_word    = buf_q << (DW_L - nbits_new);
                        buf_full_d = 1'b0;
                    end else begin
                        tx_underrun_d = 1'b1;
                    end
                    if (!spi_mode[1]) begin
                        poci_d     = tx_word[DATA_WIDTH-1];
                        tx_shift_d = tx_word << 1;
                    end else begin
                        poci_d     = 1'b0;
                        tx_shift_d = tx_word;
                    end
                end
            end
            ACTIVE: begin
                if (cs_s) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                    poci_d      = 1'b0;
                end else begin
                    if (sample_w) begin
                        rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], copi_s};
                        cnt_d      = cnt_q + 7'd1;
                        if (cnt_d == nbits_q) begin
                            state_d    = DONE;
                            rx_data_d  = rx_shift_d;
                            rx_valid_d = 1'b1;
                        end
                    end
                    if (shift_w) begin
                        poci_d     = tx_shift_q[DATA_WIDTH-1];
                        tx_shift_d = tx_shift_q << 1;
                    end
                end
            end
            DONE: begin
                if (cs_s) begin
                    state_d = IDLE;
                    poci_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (tx_valid && tx_ready) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge sync_rst_n) begin
        if (!sync_rst_n) begin
            state_q       <= IDLE;
            armed_q       <= 1'b0;
            cpol_q        <= 1'b0;
            cpha_q        <= 1'b0;
            nbits_q       <= '0;
            cnt_q         <= '0;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            buf_q         <= '0;
            buf_full_q    <= 1'b0;
            rx_data_q     <= '0;
            poci_q        <= 1'b0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            armed_q       <= armed_d;
            cpol_q        <= cpol_d;
            cpha_q        <= cpha_d;
            nbits_q       <= nbits_d;
            cnt_q         <= cnt_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            buf_q         <= buf_d;
            buf_full_q    <= buf_full_d;
            rx_data_q     <= rx_data_d;
            poci_q        <= poci_d;
            rx_valid_q    <= rx_valid_d;
            frame_err_q   <= frame_err_d;
            tx_underrun_q <= tx_underrun_d;
        end
    end

    assign tx_ready    = ~buf_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign tx_underrun = tx_underrun_q;
    assign busy        = (state_q != IDLE);
    assign poci_oe     = (state_q != IDLE);
    assign poci        = poci_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: a controller model drives directed frames,
// received words are checked by a scoreboard monitor on rx_valid.
module tb_spi_peripheral;

    localparam int HALF = 80;
    localparam int GAP  = 100;

    logic        clk = 1'b0;
    logic        sync_rst_n = 1'b0;
    logic [1:0]  spi_mode = '0;
    logic [2:0]  byte_sel = '0;
    logic [63:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [63:0] rx_data;
    logic        rx_valid, frame_err, tx_underrun, busy;
    logic        s_clk = 1'b0;
    logic        s_cs_n = 1'b1;
    logic        copi = 1'b0;
    logic        poci, poci_oe;

    always #5 clk = ~clk;

    spi_peripheral #(.DATA_WIDTH(64), .SYNC_STAGES(2)) dut (
        .clk(clk), .sync_rst_n(sync_rst_n), .spi_mode(spi_mode), .byte_sel(byte_sel),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
        .tx_underrun(tx_underrun), .busy(busy), .s_clk(s_clk), .s_cs_n(s_cs_n),
        .copi(copi), .poci(poci), .poci_oe(poci_oe)
    );

    int n_pass = 0;
    int n_chk  = 0;
    logic [63:0] exp_q[$];
    int rxv_cnt = 0, err_cnt = 0, und_cnt = 0;
    int exp_rxv = 0, exp_err = 0, exp_und = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Scoreboard monitor: pops an expected word on every rx_valid pulse.
    always @(negedge clk) begin
        if (sync_rst_n) begin
            if (rx_valid) begin
                rxv_cnt++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL rx_valid_unexpected: got rx_data %h with nothing expected", rx_data);
                end else begin
                    chk("rx_data", rx_data, exp_q.pop_front());
                end
            end
            if (frame_err) err_cnt++;
            if (tx_underrun) und_cnt++;
        end
    end

    task automatic tx_load(input logic [63:0] d);
        chk("tx_ready_before_load", {63'd0, tx_ready}, 64'd1);
        tx_data  = d;
        tx_valid = 1'b1;
        #10;
        tx_valid = 1'b0;
        chk("tx_ready_after_load", {63'd0, tx_ready}, 64'd0);
    endtask

    // Controller model: ncyc s_clk cycles, first nb poci bits collected.
    task automatic spi_xfer(input logic [1:0] mode, input int nb, input int ncyc,
                            input logic [63:0] mosi, input int abort_at,
                            output logic [63:0] miso, output logic busy_all);
        logic cpol, cpha, b;
        cpol     = mode[0];
        cpha     = mode[1];
        spi_mode = mode;
        byte_sel = 3'(nb / 8 - 1);
        miso     = '0;
        busy_all = 1'b1;
        s_clk    = cpol;
        #(HALF);
        s_cs_n = 1'b0;
        #(HALF);
        for (int i = 0; i < ncyc; i++) begin
            if (i == abort_at) break;
            b = mosi[ncyc-1-i];
            if (!cpha) begin
                copi = b;
                #(HALF);
                if (i < nb) miso = {miso[62:0], poci};
                busy_all &= busy;
                s_clk = ~cpol;
                #(HALF);
                s_clk = cpol;
            end else begin
                s_clk = ~cpol;
                copi  = b;
                #(HALF);
                if (i < nb) miso = {miso[62:0], poci};
                busy_all &= busy;
                s_clk = cpol;
                #(HALF);
            end
        end
        #(HALF);
        s_cs_n = 1'b1;
        #(GAP);
    endtask

    task automatic counts(input string tag);
        chk({tag, "_rxv_cnt"}, 64'(rxv_cnt), 64'(exp_rxv));
        chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
        chk({tag, "_und_cnt"}, 64'(und_cnt), 64'(exp_und));
    endtask

    logic [63:0] miso;
    logic        ball;

    initial begin
        #23;
        sync_rst_n = 1'b1;
        #20;
        chk("rst_tx_ready", {63'd0, tx_ready}, 64'd1);
        chk("rst_rx_data", rx_data, 64'd0);
        chk("rst_rx_valid", {63'd0, rx_valid}, 64'd0);
        chk("rst_frame_err", {63'd0, frame_err}, 64'd0);
        chk("rst_tx_underrun", {63'd0, tx_underrun}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_poci", {63'd0, poci}, 64'd0);
        chk("rst_poci_oe", {63'd0, poci_oe}, 64'd0);
        #(GAP);

        // Mode 0, one byte
        tx_load(64'hA5);
        exp_q.push_back(64'h3C); exp_rxv++;
        spi_xfer(2'd0, 8, 8, 64'h3C, 1000, miso, ball);
        chk("m0_poci", miso, 64'hA5);
        chk("m0_tx_ready_after", {63'd0, tx_ready}, 64'd1);
        chk("m0_busy_during", {63'd0, ball}, 64'd1);
        counts("m0");

        // Modes 1..3, two bytes
        for (int m = 1; m < 4; m++) begin
            tx_load(64'hBEEF);
            exp_q.push_back(64'h1234); exp_rxv++;
            spi_xfer(2'(m), 16, 16, 64'h1234, 1000, miso, ball);
            chk($sformatf("mode%0d_poci", m), miso, 64'hBEEF);
            counts($sformatf("mode%0d", m));
        end

        // Full 64-bit frame
        tx_load(64'h0123456789ABCDEF);
        exp_q.push_back(64'hFEDCBA9876543210); exp_rxv++;
        spi_xfer(2'd0, 64, 64, 64'hFEDCBA9876543210, 1000, miso, ball);
        chk("w64_poci", miso, 64'h0123456789ABCDEF);
        chk("w64_busy_during", {63'd0, ball}, 64'd1);
        counts("w64");

        // Early abort after 5 bits, then a normal frame
        tx_load(64'h55);
        exp_err++;
        spi_xfer(2'd0, 8, 8, 64'hFF, 5, miso, ball);
        chk("abort_rx_data_kept", rx_data, 64'hFEDCBA9876543210);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        counts("abort");
        tx_load(64'h18);
        exp_q.push_back(64'h81); exp_rxv++;
        spi_xfer(2'd0, 8, 8, 64'h81, 1000, miso, ball);
        chk("after_abort_poci", miso, 64'h18);
        counts("after_abort");

        // Underrun, then 10 s_clk cycles in a one-byte frame
        exp_und++;
        exp_q.push_back(64'h5A); exp_rxv++;
        spi_xfer(2'd0, 8, 8, 64'h5A, 1000, miso, ball);
        chk("underrun_poci", miso, 64'h00);
        counts("underrun");
        exp_und++;
        exp_q.push_back(64'hB4); exp_rxv++;
        spi_xfer(2'd0, 8, 10, 64'h2D3, 1000, miso, ball);
        chk("extra_clk_poci", miso, 64'h00);
        counts("extra_clk");

        // Reset after 3 bits with chip select held low
        tx_load(64'hC3);
        spi_mode = 2'd0; byte_sel = 3'd0;
        s_clk = 1'b0; #(HALF);
        s_cs_n = 1'b0; #(HALF);
        for (int i = 0; i < 3; i++) begin
            copi = 1'b1; #(HALF); s_clk = 1'b1; #(HALF); s_clk = 1'b0;
        end
        sync_rst_n = 1'b0;
        #1;
        chk("midrst_tx_ready", {63'd0, tx_ready}, 64'd1);
        chk("midrst_rx_data", rx_data, 64'd0);
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_poci_oe", {63'd0, poci_oe}, 64'd0);
        chk("midrst_poci", {63'd0, poci}, 64'd0);
        #19;
        sync_rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            copi = i[0]; #(HALF); s_clk = 1'b1; #(HALF); s_clk = 1'b0;
        end
        #(HALF);
        chk("postrst_busy", {63'd0, busy}, 64'd0);
        chk("postrst_rx_data", rx_data, 64'd0);
        counts("postrst");
        s_cs_n = 1'b1;
        #(GAP);
        tx_load(64'h66);
        exp_q.push_back(64'h99); exp_rxv++;
        spi_xfer(2'd0, 8, 8, 64'h99, 1000, miso, ball);
        chk("postrst_frame_poci", miso, 64'h66);
        counts("postrst_frame");

        chk("rx_queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
